// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART core.
// The optional parity stage is enabled with the UART_PARITY_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_t;

    // Distance of the outer vote samples from the mid-bit sample.
    localparam int MAJ_OFFSET = 1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Programmable baud tick generator: counts 0..div and pulses tick when the count equals div.
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 restart,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 tick
);

    logic [DIV_WIDTH-1:0] count_r;

    // Tick decode; a restart cycle never ticks.
    always_comb begin
        if (!restart && (count_r == div)) begin
            tick = 1'b1;
        end else begin
            tick = 1'b0;
        end
    end

    // Counter; >= also covers a divisor lowered below the current count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {DIV_WIDTH{1'b0}};
        end else if (restart || (count_r >= div)) begin
            count_r <= {DIV_WIDTH{1'b0}};
        end else begin
            count_r <= count_r + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_param_core.sv
// Parametrised full-duplex UART with oversampled, majority-voted receiver.
// Define UART_PARITY_EN to insert a parity bit after the data bits on both sides.
module uart_param_core import uart_pkg::*; #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 cfg_parity_odd,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    input  logic                 rx,
    output logic                 rx_valid,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_busy
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_LO      = SW'(OVERSAMPLE / 2 - MAJ_OFFSET);
    localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI      = SW'(OVERSAMPLE / 2 + MAJ_OFFSET);
    localparam logic [BW-1:0] B_LAST    = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // ---------------------------------------------------------------- TX
    tx_state_t            tx_state_r, tx_state_next;
    logic [SW-1:0]        tx_s_r, tx_s_next;
    logic [BW-1:0]        tx_bit_r, tx_bit_next;
    logic [DATA_BITS-1:0] tx_data_r;
    logic                 tx_r, tx_line_next;
    logic                 tx_ready_r, tx_ready_next;
    logic                 tx_busy_r, tx_busy_next;
    logic                 tx_tick, tx_restart, tx_bit_end;

    assign tx_restart = (tx_state_r == TX_IDLE) && tx_valid;

    uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_tx_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (tx_restart),
        .div     (baud_div),
        .tick    (tx_tick)
    );

    // TX state register and datapath; tx_data is captured on the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_r <= TX_IDLE;
            tx_s_r     <= {SW{1'b0}};
            tx_bit_r   <= {BW{1'b0}};
            tx_data_r  <= {DATA_BITS{1'b0}};
            tx_r       <= 1'b1;
            tx_ready_r <= 1'b1;
            tx_busy_r  <= 1'b0;
        end else begin
            tx_state_r <= tx_state_next;
            tx_s_r     <= tx_s_next;
            tx_bit_r   <= tx_bit_next;
            if (tx_restart) begin
                tx_data_r <= tx_data;
            end
            tx_r       <= tx_line_next;
            tx_ready_r <= tx_ready_next;
            tx_busy_r  <= tx_busy_next;
        end
    end

    // TX next state; tx_bit doubles as the stop-bit counter.
    always_comb begin
        tx_state_next = tx_state_r;
        tx_bit_next   = tx_bit_r;
        tx_bit_end    = tx_tick && (tx_s_r == S_LAST);
        if (tx_tick) begin
            tx_s_next = (tx_s_r == S_LAST) ? {SW{1'b0}} : tx_s_r + SW'(1);
        end else begin
            tx_s_next = tx_s_r;
        end
        case (tx_state_r)
            TX_IDLE: begin
                tx_s_next   = {SW{1'b0}};
                tx_bit_next = {BW{1'b0}};
                if (tx_valid) begin
                    tx_state_next = TX_START;
                end else begin
                    tx_state_next = TX_IDLE;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_next = TX_DATA;
                    tx_bit_next   = {BW{1'b0}};
                end else begin
                    tx_state_next = TX_START;
                end
            end
            TX_DATA: begin
                if (tx_bit_end && (tx_bit_r == B_LAST)) begin
`ifdef UART_PARITY_EN
                    tx_state_next = TX_PARITY;
`else
                    tx_state_next = TX_STOP;
`endif
                    tx_bit_next   = {BW{1'b0}};
                end else if (tx_bit_end) begin
                    tx_bit_next = tx_bit_r + BW'(1);
                end else begin
                    tx_state_next = TX_DATA;
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_next = TX_STOP;
                    tx_bit_next   = {BW{1'b0}};
                end else begin
                    tx_state_next = TX_PARITY;
                end
            end
            TX_STOP: begin
                if (tx_bit_end && (tx_bit_r == STOP_LAST)) begin
                    tx_state_next = TX_IDLE;
                end else if (tx_bit_end) begin
                    tx_bit_next = tx_bit_r + BW'(1);
                end else begin
                    tx_state_next = TX_STOP;
                end
            end
            default: begin
                tx_state_next = TX_IDLE;
            end
        endcase
    end

    // TX outputs, decoded from the next state so the line is registered.
    always_comb begin
        tx_ready_next = (tx_state_next == TX_IDLE);
        tx_busy_next  = (tx_state_next != TX_IDLE);
        case (tx_state_next)
            TX_IDLE:   tx_line_next = 1'b1;
            TX_START:  tx_line_next = 1'b0;
            TX_DATA:   tx_line_next = tx_data_r[tx_bit_next];
            TX_PARITY: tx_line_next = calc_parity(tx_data_r, cfg_parity_odd);
            TX_STOP:   tx_line_next = 1'b1;
            default:   tx_line_next = 1'b1;
        endcase
    end

    assign tx       = tx_r;
    assign tx_ready = tx_ready_r;
    assign tx_busy  = tx_busy_r;

    // ---------------------------------------------------------------- RX
    rx_state_t            rx_state_r, rx_state_next;
    logic [SW-1:0]        rx_s_r, rx_s_next;
    logic [BW-1:0]        rx_bit_r, rx_bit_next;
    logic [1:0]           rx_samp_r;
    logic [DATA_BITS-1:0] rx_shift_r;
    logic                 rx_meta_r, rx_sync_r;
    logic                 rx_valid_r, rx_valid_next;
    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_frame_err_r, rx_parity_err_r;
    logic                 rx_busy_r, rx_busy_next;
    logic                 rx_tick, rx_restart, rx_decide, rx_bit_end, rx_maj;
`ifdef UART_PARITY_EN
    logic                 rx_par_r;
`endif

    assign rx_restart = (rx_state_r == RX_IDLE) && !rx_sync_r;

    uart_baud_gen #(.DIV_WIDTH(DIV_WIDTH)) u_rx_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (rx_restart),
        .div     (baud_div),
        .tick    (rx_tick)
    );

    // RX synchroniser, state register, sampling and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r       <= 1'b1;
            rx_sync_r       <= 1'b1;
            rx_state_r      <= RX_IDLE;
            rx_s_r          <= {SW{1'b0}};
            rx_bit_r        <= {BW{1'b0}};
            rx_samp_r       <= 2'b11;
            rx_shift_r      <= {DATA_BITS{1'b0}};
            rx_valid_r      <= 1'b0;
            rx_data_r       <= {DATA_BITS{1'b0}};
            rx_frame_err_r  <= 1'b0;
            rx_parity_err_r <= 1'b0;
            rx_busy_r       <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_r        <= 1'b0;
`endif
        end else begin
            rx_meta_r  <= rx;
            rx_sync_r  <= rx_meta_r;
            rx_state_r <= rx_state_next;
            rx_s_r     <= rx_s_next;
            rx_bit_r   <= rx_bit_next;
            rx_valid_r <= rx_valid_next;
            rx_busy_r  <= rx_busy_next;
            if (rx_tick && ((rx_s_r == S_LO) || (rx_s_r == S_MID))) begin
                rx_samp_r <= {rx_samp_r[0], rx_sync_r};
            end
            if (rx_decide && (rx_state_r == RX_DATA)) begin
                rx_shift_r <= {rx_maj, rx_shift_r[DATA_BITS-1:1]};
            end
`ifdef UART_PARITY_EN
            if (rx_decide && (rx_state_r == RX_PARITY)) begin
                rx_par_r <= rx_maj;
            end
`endif
            if (rx_valid_next) begin
                rx_data_r      <= rx_shift_r;
                rx_frame_err_r <= ~rx_maj;
`ifdef UART_PARITY_EN
                rx_parity_err_r <= (rx_par_r != calc_parity(rx_shift_r, cfg_parity_odd));
`else
                rx_parity_err_r <= 1'b0;
`endif
            end
        end
    end

    // RX next state; bits are decided on the third vote sample.
    always_comb begin
        rx_state_next = rx_state_r;
        rx_bit_next   = rx_bit_r;
        rx_decide     = rx_tick && (rx_s_r == S_HI);
        rx_bit_end    = rx_tick && (rx_s_r == S_LAST);
        rx_maj        = maj3(rx_samp_r[1], rx_samp_r[0], rx_sync_r);
        if (rx_tick) begin
            rx_s_next = (rx_s_r == S_LAST) ? {SW{1'b0}} : rx_s_r + SW'(1);
        end else begin
            rx_s_next = rx_s_r;
        end
        case (rx_state_r)
            RX_IDLE: begin
                rx_s_next   = {SW{1'b0}};
                rx_bit_next = {BW{1'b0}};
                if (!rx_sync_r) begin
                    rx_state_next = RX_START;
                end else begin
                    rx_state_next = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_decide && rx_maj) begin
                    rx_state_next = RX_IDLE;
                end else if (rx_bit_end) begin
                    rx_state_next = RX_DATA;
                    rx_bit_next   = {BW{1'b0}};
                end else begin
                    rx_state_next = RX_START;
                end
            end
            RX_DATA: begin
                if (rx_bit_end && (rx_bit_r == B_LAST)) begin
`ifdef UART_PARITY_EN
                    rx_state_next = RX_PARITY;
`else
                    rx_state_next = RX_STOP;
`endif
                end else if (rx_bit_end) begin
                    rx_bit_next = rx_bit_r + BW'(1);
                end else begin
                    rx_state_next = RX_DATA;
                end
            end
            RX_PARITY: begin
                if (rx_bit_end) begin
                    rx_state_next = RX_STOP;
                end else begin
                    rx_state_next = RX_PARITY;
                end
            end
            RX_STOP: begin
                if (rx_decide) begin
                    rx_state_next = RX_IDLE;
                end else begin
                    rx_state_next = RX_STOP;
                end
            end
            default: begin
                rx_state_next = RX_IDLE;
            end
        endcase
    end

    // RX outputs: completion pulse on the stop-bit decision.
    always_comb begin
        rx_busy_next = (rx_state_next != RX_IDLE);
        if ((rx_state_r == RX_STOP) && rx_decide) begin
            rx_valid_next = 1'b1;
        end else begin
            rx_valid_next = 1'b0;
        end
    end

    assign rx_valid      = rx_valid_r;
    assign rx_data       = rx_data_r;
    assign rx_frame_err  = rx_frame_err_r;
    assign rx_parity_err = rx_parity_err_r;
    assign rx_busy       = rx_busy_r;

endmodule

// File: tb/tb_uart_param_core.sv
// Directed self-checking bench for uart_param_core (8 data bits, 1 stop, 16x, baud_div=3).
`timescale 1ns/1ps
module tb_uart_param_core;

`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int BIT_CLKS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] baud_div;
    logic        cfg_parity_odd;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx;
    logic        tx_busy;
    logic        rx_line;
    logic        rx_man;
    logic        loop_en;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_frame_err;
    logic        rx_parity_err;
    logic        rx_busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] rxd_q[$];
    logic       rxf_q[$];
    logic       rxp_q[$];
    int         hs_q[$];

    assign rx_line = loop_en ? tx : rx_man;

    always #5 clk = ~clk;

    uart_param_core #(
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .OVERSAMPLE (16),
        .DIV_WIDTH  (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .baud_div       (baud_div),
        .cfg_parity_odd (cfg_parity_odd),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .tx_data        (tx_data),
        .tx             (tx),
        .tx_busy        (tx_busy),
        .rx             (rx_line),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .rx_frame_err   (rx_frame_err),
        .rx_parity_err  (rx_parity_err),
        .rx_busy        (rx_busy)
    );

    // Record received frames and TX handshakes with their cycle numbers.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_valid) begin
            rxd_q.push_back(rx_data);
            rxf_q.push_back(rx_frame_err);
            rxp_q.push_back(rx_parity_err);
        end
        if (tx_valid && tx_ready && !rst) begin
            hs_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] make_frame(input logic [7:0] d, input logic par, input logic stop);
        logic [11:0] f;
        f      = 12'hFFF;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_PARITY_EN
        f[9]   = par;
        f[10]  = stop;
`else
        f[9]   = stop;
`endif
        return f;
    endfunction

    task automatic drive_frame(input logic [11:0] f, input int gbit, input logic gon);
        for (int i = 0; i < NB; i++) begin
            for (int c = 0; c < BIT_CLKS; c++) begin
                rx_man = f[i] ^ (gon && (i == gbit) && (c >= 34) && (c <= 37));
                @(negedge clk);
            end
        end
        rx_man = 1'b1;
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; (i < budget) && (rxd_q.size() < n); i++) begin
            @(negedge clk);
        end
        check("rx_frame_count", rxd_q.size(), n);
    endtask

    task automatic send_tx(input logic [7:0] d);
        int n;
        n        = hs_q.size();
        tx_data  = d;
        tx_valid = 1'b1;
        for (int i = 0; (i < 2000) && (hs_q.size() == n); i++) begin
            @(negedge clk);
        end
        check("tx_handshake", hs_q.size(), n + 1);
    endtask

    task automatic check_rx(input int idx, input logic [7:0] d, input logic fe, input logic pe);
        if (idx < rxd_q.size()) begin
            check("rx_data", rxd_q[idx], d);
            check("rx_frame_err", rxf_q[idx], fe);
            check("rx_parity_err", rxp_q[idx], pe);
        end else begin
            check("rx_present", rxd_q.size(), idx + 1);
        end
    endtask

    initial begin
        logic [11:0] f;
        int          bad;
        int          low_cnt;
        int          r0;
        int          h0;
        int          g;

        rst            = 1'b1;
        baud_div       = 16'd3;
        cfg_parity_odd = 1'b1;
        tx_valid       = 1'b0;
        tx_data        = 8'h00;
        rx_man         = 1'b1;
        loop_en        = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_tx_busy", tx_busy, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_errs", {rx_frame_err, rx_parity_err}, 2'b00);
        check("rst_rx_busy", rx_busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Basic TX of 0xA5: every bit 64 clocks, tx_ready low for the whole frame.
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        f        = make_frame(8'hA5, 1'b1, 1'b1);
        low_cnt  = 0;
        for (int b = 0; b < NB; b++) begin
            bad = 0;
            for (int c = 0; c < BIT_CLKS; c++) begin
                if (tx !== f[b]) bad++;
                if (!tx_ready) low_cnt++;
                @(negedge clk);
            end
            check("tx_bit_mismatch_cycles", bad, 0);
        end
        check("tx_ready_low_cycles", low_cnt, NB * BIT_CLKS);
        check("tx_ready_after_frame", tx_ready, 1'b1);
        check("tx_idle_after_frame", tx, 1'b1);

        // Loopback of three back-to-back bytes.
        loop_en = 1'b1;
        r0      = rxd_q.size();
        h0      = hs_q.size();
        send_tx(8'h00);
        send_tx(8'hFF);
        send_tx(8'h3C);
        tx_valid = 1'b0;
        for (int k = 1; k < 3; k++) begin
            g = (h0 + k < hs_q.size()) ? hs_q[h0 + k] - hs_q[h0 + k - 1] : 0;
            check("tx_back_to_back_spacing_ok", (g >= NB * BIT_CLKS) && (g <= NB * BIT_CLKS + 1), 1'b1);
        end
        wait_rx(r0 + 3, 3000);
        check_rx(r0, 8'h00, 1'b0, 1'b0);
        check_rx(r0 + 1, 8'hFF, 1'b0, 1'b0);
        check_rx(r0 + 2, 8'h3C, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        loop_en = 1'b0;

        // False start: 16 clocks low.
        r0     = rxd_q.size();
        rx_man = 1'b0;
        repeat (16) @(negedge clk);
        check("false_start_busy", rx_busy, 1'b1);
        rx_man = 1'b1;
        repeat (100) @(negedge clk);
        check("false_start_no_valid", rxd_q.size(), r0);
        check("false_start_idle", rx_busy, 1'b0);

        // One-tick glitch at the mid sample of data bit 3 is outvoted.
        drive_frame(make_frame(8'h3C, 1'b1, 1'b1), 4, 1'b1);
        wait_rx(r0 + 1, 200);
        check_rx(r0, 8'h3C, 1'b0, 1'b0);
        repeat (20) @(negedge clk);

        // Framing error, then a clean frame.
        r0 = rxd_q.size();
        drive_frame(make_frame(8'h3C, 1'b1, 1'b0), 0, 1'b0);
        wait_rx(r0 + 1, 200);
        check_rx(r0, 8'h3C, 1'b1, 1'b0);
        repeat (200) @(negedge clk);
        check("after_frame_err_no_extra", rxd_q.size(), r0 + 1);
        check("after_frame_err_idle", rx_busy, 1'b0);
        drive_frame(make_frame(8'hA5, 1'b1, 1'b1), 0, 1'b0);
        wait_rx(r0 + 2, 200);
        check_rx(r0 + 1, 8'hA5, 1'b0, 1'b0);
        repeat (20) @(negedge clk);

        // 0x03 with parity bit 0: odd parity expects 1.
        r0 = rxd_q.size();
        drive_frame(make_frame(8'h03, 1'b0, 1'b1), 0, 1'b0);
        wait_rx(r0 + 1, 200);
`ifdef UART_PARITY_EN
        check_rx(r0, 8'h03, 1'b0, 1'b1);
        // TX 0x01 with odd parity sends parity bit 0.
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (9 * BIT_CLKS + 32 - 1) @(negedge clk);
        check("tx_parity_bit_0x01", tx, 1'b0);
        for (int i = 0; (i < 1000) && !tx_ready; i++) @(negedge clk);
        check("tx_parity_frame_done", tx_ready, 1'b1);
`else
        check_rx(r0, 8'h03, 1'b0, 1'b0);
`endif
        repeat (20) @(negedge clk);

        // Reset 200 clocks into a TX frame and 300 clocks into an RX frame.
        r0 = rxd_q.size();
        f  = make_frame(8'h96, 1'b1, 1'b1);
        for (int c = 0; c < 300; c++) begin
            rx_man   = f[c / BIT_CLKS];
            tx_valid = (c == 100);
            tx_data  = 8'h5A;
            @(negedge clk);
        end
        check("tx_low_before_rst", tx, 1'b0);
        rst    = 1'b1;
        rx_man = 1'b1;
        @(negedge clk);
        check("rst_mid_tx_high", tx, 1'b1);
        check("rst_mid_tx_ready", tx_ready, 1'b1);
        check("rst_mid_rx_busy", rx_busy, 1'b0);
        rst = 1'b0;
        repeat (1000) @(negedge clk);
        check("rst_mid_no_rx_valid", rxd_q.size(), r0);
        check("rst_mid_tx_ready_after", tx_ready, 1'b1);
        loop_en = 1'b1;
        send_tx(8'h5A);
        tx_valid = 1'b0;
        wait_rx(r0 + 1, 1500);
        check_rx(r0, 8'h5A, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
